// File: rtl/riscv_wb_stage_if.sv
// ---------------------------------------------------------------------------
// riscv_wb_stage_if
// Bundles the MEM-stage request, the data-memory response and the register
// file write port seen by the writeback stage.
//   master : MEM stage / memory side (drives *_i, observes *_o)
//   slave  : writeback stage (observes *_i, drives *_o)
// Ports: none (clock and reset stay plain ports on the modules).
// ---------------------------------------------------------------------------
interface riscv_wb_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) ();
    // MEM stage request
    logic              valid_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              rd_we_i;
    logic              is_load_i;
    logic [2:0]        funct3_i;
    logic [XLEN-1:0]   alu_result_i;
    // data-memory response
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    // writeback side
    logic              stall_o;
    logic              rf_we_o;
    logic [REG_AW-1:0] rf_waddr_o;
    logic [XLEN-1:0]   rf_wdata_o;
    logic              misalign_o;
    logic [CNT_W-1:0]  instret_o;

    modport master (
        output valid_i, rd_addr_i, rd_we_i, is_load_i, funct3_i, alu_result_i,
               mem_rvalid_i, mem_rdata_i,
        input  stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, misalign_o, instret_o
    );

    modport slave (
        input  valid_i, rd_addr_i, rd_we_i, is_load_i, funct3_i, alu_result_i,
               mem_rvalid_i, mem_rdata_i,
        output stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, misalign_o, instret_o
    );
endinterface

// File: rtl/riscv_wb_stage.sv
// ---------------------------------------------------------------------------
// riscv_wb_stage
// Registered writeback stage. Non-loads write one cycle after acceptance.
// Loads park in WAIT until the memory response, then the selected byte /
// half / word / double is aligned, extended and written one cycle later.
// Misaligned or illegal loads are dropped with a one-cycle misalign pulse.
// A retired-instruction counter tracks committed results.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active high
//   bus  - riscv_wb_stage_if.slave (request, memory response, RF write,
//          stall, misalign pulse, instret)
// ---------------------------------------------------------------------------
module riscv_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    riscv_wb_stage_if.slave   bus
);
    localparam int OFF_W = $clog2(XLEN/8);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nxt;

    // load context captured at acceptance
    logic [REG_AW-1:0] ld_rd;
    logic              ld_we;
    logic [2:0]        ld_f3;
    logic [OFF_W-1:0]  ld_off;

    // next values of the registered outputs
    logic              we_nxt;
    logic              mis_nxt;
    logic              ret_nxt;
    logic [REG_AW-1:0] waddr_nxt;
    logic [XLEN-1:0]   wdata_nxt;

    // formatted load data and its legality
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   fmt;
    logic              bad;

    logic accept_alu, accept_ld, resp;

    assign bus.stall_o = (state == WAIT);
    assign accept_alu  = (state == IDLE) && bus.valid_i && !bus.is_load_i;
    assign accept_ld   = (state == IDLE) && bus.valid_i &&  bus.is_load_i;
    assign resp        = (state == WAIT) && bus.mem_rvalid_i;

    // ---- state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_ld)        state_nxt = WAIT;
            WAIT:    if (bus.mem_rvalid_i) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // ---- load formatting ----
    // Bring the addressed bytes down to bit 0, then extend by size/sign.
    always_comb begin
        shifted = bus.mem_rdata_i >> {ld_off, 3'b000};
        fmt     = '0;
        bad     = 1'b0;
        case (ld_f3)
            3'b000: fmt = XLEN'($signed(shifted[7:0]));
            3'b100: fmt = XLEN'(shifted[7:0]);
            3'b001: begin
                fmt = XLEN'($signed(shifted[15:0]));
                bad = ld_off[0];
            end
            3'b101: begin
                fmt = XLEN'(shifted[15:0]);
                bad = ld_off[0];
            end
            3'b010: begin
                fmt = XLEN'($signed(shifted[31:0]));
                bad = (ld_off[1:0] != 2'b00);
            end
            3'b110: begin
                // LWU only exists on RV64
                fmt = XLEN'(shifted[31:0]);
                bad = (XLEN == 32) || (ld_off[1:0] != 2'b00);
            end
            3'b011: begin
                // LD only exists on RV64; full-width pass-through
                fmt = shifted;
                bad = (XLEN == 32) || (ld_off != '0);
            end
            default: bad = 1'b1;
        endcase
    end

    // ---- output logic ----
    // Address/data only move on a real write so they hold otherwise.
    always_comb begin
        we_nxt    = 1'b0;
        mis_nxt   = 1'b0;
        ret_nxt   = 1'b0;
        waddr_nxt = bus.rf_waddr_o;
        wdata_nxt = bus.rf_wdata_o;
        case (state)
            IDLE: begin
                if (accept_alu) begin
                    ret_nxt = 1'b1;
                    we_nxt  = bus.rd_we_i && (bus.rd_addr_i != '0);
                    if (we_nxt) begin
                        waddr_nxt = bus.rd_addr_i;
                        wdata_nxt = bus.alu_result_i;
                    end
                end
            end
            WAIT: begin
                if (resp) begin
                    if (bad) begin
                        mis_nxt = 1'b1;
                    end else begin
                        ret_nxt = 1'b1;
                        we_nxt  = ld_we && (ld_rd != '0);
                        if (we_nxt) begin
                            waddr_nxt = ld_rd;
                            wdata_nxt = fmt;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // ---- load context capture ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_rd  <= '0;
            ld_we  <= 1'b0;
            ld_f3  <= '0;
            ld_off <= '0;
        end else if (accept_ld) begin
            ld_rd  <= bus.rd_addr_i;
            ld_we  <= bus.rd_we_i;
            ld_f3  <= bus.funct3_i;
            ld_off <= bus.alu_result_i[OFF_W-1:0];
        end
    end

    // ---- registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we_o    <= 1'b0;
            bus.rf_waddr_o <= '0;
            bus.rf_wdata_o <= '0;
            bus.misalign_o <= 1'b0;
            bus.instret_o  <= '0;
        end else begin
            bus.rf_we_o    <= we_nxt;
            bus.rf_waddr_o <= waddr_nxt;
            bus.rf_wdata_o <= wdata_nxt;
            bus.misalign_o <= mis_nxt;
            if (ret_nxt) bus.instret_o <= bus.instret_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_wb_stage.sv
module tb_riscv_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) b ();
    riscv_wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(8))  b8 ();

    riscv_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    riscv_wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(b8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [63:0] m_ret;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level load semantics: size from funct3[1:0], sign from funct3[2].
    task automatic ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] data,
                            output logic bad, output logic [31:0] val);
        int nbytes;
        longint unsigned raw, mask;
        nbytes = 1 << f3[1:0];
        bad = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || ((int'(off) % nbytes) != 0);
        mask = (64'd1 << (nbytes * 8)) - 1;
        raw  = (longint'(data) >> (int'(off) * 8)) & mask;
        if (!f3[2] && raw[nbytes*8-1]) raw = raw | ~mask;
        val = raw[31:0];
    endtask

    task automatic idle_inputs();
        b.valid_i = 0; b.rd_addr_i = 0; b.rd_we_i = 0; b.is_load_i = 0;
        b.funct3_i = 0; b.alu_result_i = 0; b.mem_rvalid_i = 0; b.mem_rdata_i = 0;
    endtask

    task automatic check_outs(input string tag, input logic exp_we, input logic exp_mis);
        chk({tag, ".we"},    64'(b.rf_we_o),    64'(exp_we));
        chk({tag, ".mis"},   64'(b.misalign_o), 64'(exp_mis));
        chk({tag, ".waddr"}, 64'(b.rf_waddr_o), 64'(m_waddr));
        chk({tag, ".wdata"}, 64'(b.rf_wdata_o), 64'(m_wdata));
        chk({tag, ".ret"},   b.instret_o,       m_ret);
        chk({tag, ".stall"}, 64'(b.stall_o),    64'd0);
    endtask

    task automatic alu_op(input string tag, input logic [4:0] rd, input logic we, input logic [31:0] v);
        logic w;
        b.valid_i = 1; b.is_load_i = 0; b.rd_addr_i = rd; b.rd_we_i = we;
        b.alu_result_i = v; b.funct3_i = 3'($urandom); b.mem_rvalid_i = 1'($urandom);
        b.mem_rdata_i = $urandom;
        tick();
        idle_inputs();
        w = we && (rd != 0);
        m_ret++;
        if (w) begin m_waddr = rd; m_wdata = v; end
        check_outs(tag, w, 0);
    endtask

    task automatic load_op(input string tag, input logic [4:0] rd, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data, input int lat);
        logic bad, w;
        logic [31:0] val;
        b.valid_i = 1; b.is_load_i = 1; b.rd_addr_i = rd; b.rd_we_i = we;
        b.funct3_i = f3; b.alu_result_i = addr;
        b.mem_rvalid_i = 1'($urandom); b.mem_rdata_i = $urandom;   // ignored at acceptance
        tick();
        idle_inputs();
        b.valid_i = 1'($urandom); b.alu_result_i = $urandom;       // must be held off by stall
        chk({tag, ".stall0"}, 64'(b.stall_o), 64'd1);
        chk({tag, ".nowe"},   64'(b.rf_we_o), 64'd0);
        repeat (lat - 1) begin
            tick();
            chk({tag, ".stallw"}, 64'(b.stall_o), 64'd1);
        end
        b.mem_rvalid_i = 1; b.mem_rdata_i = data;
        tick();
        idle_inputs();
        ref_load(f3, addr[1:0], data, bad, val);
        w = !bad && we && (rd != 0);
        if (!bad) m_ret++;
        if (w) begin m_waddr = rd; m_wdata = val; end
        check_outs(tag, w, bad);
    endtask

    initial begin
        logic [63:0] r8;
        idle_inputs();
        b8.valid_i = 0; b8.rd_addr_i = 1; b8.rd_we_i = 1; b8.is_load_i = 0;
        b8.funct3_i = 0; b8.alu_result_i = 0; b8.mem_rvalid_i = 0; b8.mem_rdata_i = 0;
        m_ret = 0; m_waddr = 0; m_wdata = 0;
        #12;
        check_outs("reset", 0, 0);
        rst = 0;
        tick();

        alu_op("alu_rd5", 5'd5, 1, 32'h1234);
        load_op("lb",   5'd6, 1, 3'b000, 32'h1003, 32'h80AA55CC, 3);
        chk("lb.val", 64'(b.rf_wdata_o), 64'hFFFFFF80);
        load_op("lbu",  5'd6, 1, 3'b100, 32'h1003, 32'h80AA55CC, 3);
        chk("lbu.val", 64'(b.rf_wdata_o), 64'h00000080);
        load_op("lh",   5'd8, 1, 3'b001, 32'h2002, 32'h9ABC1234, 1);
        chk("lh.val", 64'(b.rf_wdata_o), 64'hFFFF9ABC);
        load_op("lhu_mis", 5'd9, 1, 3'b101, 32'h2001, 32'h9ABC1234, 2);
        chk("lhu_mis.pulse", 64'(b.misalign_o), 64'd1);
        alu_op("alu_x0", 5'd0, 1, 32'hDEAD);
        load_op("ld_ill", 5'd3, 1, 3'b011, 32'h0, 32'h1, 1);
        load_op("lw_x0", 5'd0, 1, 3'b010, 32'h4, 32'h55, 2);

        // response while idle must do nothing
        b.mem_rvalid_i = 1; b.mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        check_outs("rv_idle", 0, 0);

        // load followed by an ALU op that is held by stall
        b.valid_i = 1; b.is_load_i = 1; b.rd_addr_i = 3; b.rd_we_i = 1;
        b.funct3_i = 3'b010; b.alu_result_i = 32'h100;
        tick();
        b.is_load_i = 0; b.rd_addr_i = 7; b.alu_result_i = 32'hCAFE;
        tick();
        chk("b2b.stall", 64'(b.stall_o), 64'd1);
        b.mem_rvalid_i = 1; b.mem_rdata_i = 32'h0BADF00D;
        tick();
        b.mem_rvalid_i = 0;
        m_ret++; m_waddr = 3; m_wdata = 32'h0BADF00D;
        check_outs("b2b.ld", 1, 0);
        tick();
        idle_inputs();
        m_ret++; m_waddr = 7; m_wdata = 32'hCAFE;
        check_outs("b2b.alu", 1, 0);
        tick();
        check_outs("b2b.nodup", 0, 0);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                alu_op("rnd_alu", 5'($urandom), 1'($urandom), $urandom);
            else
                load_op("rnd_ld", 5'($urandom), 1'($urandom), 3'($urandom), $urandom,
                        $urandom, $urandom_range(1, 4));
        end

        // reset while waiting abandons the load
        b.valid_i = 1; b.is_load_i = 1; b.rd_addr_i = 4; b.rd_we_i = 1;
        b.funct3_i = 3'b010; b.alu_result_i = 0;
        tick();
        idle_inputs();
        tick();
        rst = 1;
        #1;
        m_ret = 0; m_waddr = 0; m_wdata = 0;
        check_outs("rst_wait", 0, 0);
        #2;
        rst = 0;
        b.mem_rvalid_i = 1; b.mem_rdata_i = 32'h12345678;
        tick();
        idle_inputs();
        check_outs("rst_after", 0, 0);

        // narrow counter wraps
        r8 = 0;
        b8.valid_i = 1;
        repeat (255) begin tick(); r8 = (r8 + 1) % 256; end
        chk("wrap.ff", 64'(b8.instret_o), r8);
        tick();
        r8 = (r8 + 1) % 256;
        b8.valid_i = 0;
        chk("wrap.zero", 64'(b8.instret_o), r8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
